// File: rtl/tile_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tile_draw_arbiter
//
// Shared pixel-write engine for the VGA adapter. Several tile-draw requesters
// compete for one pixel port. The winner's TILE x TILE block is rasterised
// row-major, one pixel per clock. Each draw takes TILE*TILE cycles plus one
// DONE cycle plus one IDLE cycle.
//
// Ports
//   CLOCK_50   in   system clock, all state on rising edge
//   reset      in   asynchronous, active-high reset
//   req        in   level request per channel
//   tile_x     in   tile x per channel, ch i at [i*TILE_BITS +: TILE_BITS]
//   tile_y     in   tile y per channel, same packing
//   colour_in  in   fill colour per channel, ch i at [i*COLOUR_W +: COLOUR_W]
//   grant      out  one-hot owner of the current draw (DRAW and DONE)
//   done       out  one-cycle pulse on the granted channel at end of draw
//   busy       out  high in DRAW and DONE
//   x, y       out  pixel coordinate to the VGA adapter
//   colour     out  pixel colour to the VGA adapter
//   plot       out  pixel write enable (low for clipped pixels)
// -----------------------------------------------------------------------------
module tile_draw_arbiter #(
  parameter int N_CH      = 3,
  parameter int TILE      = 4,
  parameter int TILE_BITS = 5,
  parameter int COLOUR_W  = 3,
  parameter int X_W       = 9,
  parameter int Y_W       = 9,
  parameter int X_ORIGIN  = 0,
  parameter int Y_ORIGIN  = 0,
  parameter int X_MAX     = 320,
  parameter int Y_MAX     = 240,
  parameter int RR_MODE   = 0
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH*TILE_BITS-1:0] tile_x,
  input  logic [N_CH*TILE_BITS-1:0] tile_y,
  input  logic [N_CH*COLOUR_W-1:0]  colour_in,
  output logic [N_CH-1:0]           grant,
  output logic [N_CH-1:0]           done,
  output logic                      busy,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [COLOUR_W-1:0]       colour,
  output logic                      plot
);

  localparam int TILE_LOG = $clog2(TILE);
  localparam int PW       = (TILE > 1) ? TILE_LOG : 1;
  localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TILE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t                state, state_d;
  logic [PW-1:0]         px, py, px_d, py_d, npx, npy;
  logic [TILE_BITS-1:0]  tx_l, ty_l, tx_d, ty_d;
  logic [TILE_BITS-1:0]  sel_tx, sel_ty, src_tx, src_ty;
  logic [COLOUR_W-1:0]   col_l, col_d, sel_col, colour_d;
  logic [CW-1:0]         ptr, ptr_d, win, win_lo, win_hi;
  logic                  hi_found;
  logic [X_W-1:0]        x_calc, x_d;
  logic [Y_W-1:0]        y_calc, y_d;
  logic                  pix_on, last_pix;
  logic [N_CH-1:0]       grant_d, done_d;
  logic                  busy_d, plot_d;

  // Arbitration. Descending scan leaves the lowest set index in win_lo and
  // the lowest set index above the pointer in win_hi; round-robin prefers
  // win_hi and wraps to win_lo.
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    win_lo   = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = CW'(i);
        if (CW'(i) > ptr) begin
          win_hi   = CW'(i);
          hi_found = 1'b1;
        end
      end
    end
    if (RR_MODE != 0 && hi_found) win = win_hi;
    else                          win = win_lo;
  end

  // Winner's tile and colour, taken straight from the inputs in IDLE.
  always_comb begin
    sel_tx  = '0;
    sel_ty  = '0;
    sel_col = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CW'(i) == win) begin
        sel_tx  = tile_x[i*TILE_BITS +: TILE_BITS];
        sel_ty  = tile_y[i*TILE_BITS +: TILE_BITS];
        sel_col = colour_in[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  // Coordinate of the pixel that goes on the outputs at the next edge: pixel
  // (0,0) of the new winner from IDLE, otherwise the successor of (px,py).
  always_comb begin
    src_tx = tx_l;
    src_ty = ty_l;
    npx    = '0;
    npy    = '0;
    if (state == S_IDLE) begin
      src_tx = sel_tx;
      src_ty = sel_ty;
    end else if (px == P_LAST) begin
      npy = py + PW'(1);
    end else begin
      npx = px + PW'(1);
      npy = py;
    end
    x_calc   = X_W'(X_ORIGIN) + (X_W'(src_tx) << TILE_LOG) + X_W'(npx);
    y_calc   = Y_W'(Y_ORIGIN) + (Y_W'(src_ty) << TILE_LOG) + Y_W'(npy);
    pix_on   = (32'(x_calc) < X_MAX) && (32'(y_calc) < Y_MAX);
    last_pix = (px == P_LAST) && (py == P_LAST);
  end

  // Next-state and next-output logic; everything is registered below.
  always_comb begin
    state_d  = state;
    grant_d  = grant;
    done_d   = '0;
    busy_d   = busy;
    plot_d   = plot;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    px_d     = px;
    py_d     = py;
    tx_d     = tx_l;
    ty_d     = ty_l;
    col_d    = col_l;
    ptr_d    = ptr;
    case (state)
      S_IDLE: begin
        plot_d = 1'b0;
        if (|req) begin
          state_d  = S_DRAW;
          grant_d  = N_CH'(1) << win;
          busy_d   = 1'b1;
          ptr_d    = win;
          tx_d     = sel_tx;
          ty_d     = sel_ty;
          col_d    = sel_col;
          px_d     = '0;
          py_d     = '0;
          x_d      = x_calc;
          y_d      = y_calc;
          colour_d = sel_col;
          plot_d   = pix_on;
        end
      end
      S_DRAW: begin
        if (last_pix) begin
          state_d = S_DONE;
          plot_d  = 1'b0;
          done_d  = grant;
        end else begin
          px_d   = npx;
          py_d   = npy;
          x_d    = x_calc;
          y_d    = y_calc;
          plot_d = pix_on;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      px     <= '0;
      py     <= '0;
      tx_l   <= '0;
      ty_l   <= '0;
      col_l  <= '0;
      ptr    <= CW'(N_CH - 1);
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state  <= state_d;
      grant  <= grant_d;
      done   <= done_d;
      busy   <= busy_d;
      plot   <= plot_d;
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
      px     <= px_d;
      py     <= py_d;
      tx_l   <= tx_d;
      ty_l   <= ty_d;
      col_l  <= col_d;
      ptr    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tile_draw_arbiter
//
// Four arbiters share one clock and reset:
//   0: all defaults (fixed priority)
//   1: round-robin
//   2: TILE_BITS=7, so tiles up to the screen edge are reachable
//   3: TILE_BITS=7 with X_ORIGIN=4
// Expected pixels are queued when a draw is requested and popped as the DUT
// emits them.
// -----------------------------------------------------------------------------
module tb_tile_draw_arbiter;

  localparam int NI = 4;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] req_v    [NI];
  logic [6:0] tx_v     [NI][3];
  logic [6:0] ty_v     [NI][3];
  logic [2:0] col_v    [NI][3];
  logic [2:0] grant_v  [NI];
  logic [2:0] done_v   [NI];
  logic       busy_v   [NI];
  logic       plot_v   [NI];
  logic [8:0] x_v      [NI];
  logic [8:0] y_v      [NI];
  logic [2:0] colour_v [NI];

  pix_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int TB = (g >= 2) ? 7 : 5;
    logic [3*TB-1:0] txb, tyb;
    logic [8:0]      colb;
    assign txb  = {tx_v[g][2][TB-1:0], tx_v[g][1][TB-1:0], tx_v[g][0][TB-1:0]};
    assign tyb  = {ty_v[g][2][TB-1:0], ty_v[g][1][TB-1:0], ty_v[g][0][TB-1:0]};
    assign colb = {col_v[g][2], col_v[g][1], col_v[g][0]};

    tile_draw_arbiter #(
      .TILE_BITS (TB),
      .RR_MODE   ((g == 1) ? 1 : 0),
      .X_ORIGIN  ((g == 3) ? 4 : 0)
    ) u_dut (
      .CLOCK_50  (clk),
      .reset     (rst),
      .req       (req_v[g]),
      .tile_x    (txb),
      .tile_y    (tyb),
      .colour_in (colb),
      .grant     (grant_v[g]),
      .done      (done_v[g]),
      .busy      (busy_v[g]),
      .x         (x_v[g]),
      .y         (y_v[g]),
      .colour    (colour_v[g]),
      .plot      (plot_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Model of the rasteriser: 16 pixels row-major, 9-bit wrap, clip at 320x240.
  task automatic push_tile(input int k, input int tx, input int ty, input logic [2:0] col);
    int org;
    org = (k == 3) ? 4 : 0;
    for (int py = 0; py < 4; py++) begin
      for (int px = 0; px < 4; px++) begin
        pix_t e;
        int   xi, yi;
        xi  = (org + tx * 4 + px) % 512;
        yi  = (ty * 4 + py) % 512;
        e.x = 9'(xi);
        e.y = 9'(yi);
        e.c = col;
        e.p = (xi < 320) && (yi < 240);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called on a negedge; returns on the first negedge with grant visible.
  task automatic wait_grant(input int k, input logic [2:0] exp_g, input string tag, output int at);
    int n;
    n = 0;
    while (grant_v[k] == 3'b000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    check({tag, "/grant"}, 32'(grant_v[k]), 32'(exp_g));
  endtask

  // Checks the 16 DRAW cycles, the DONE cycle and the following IDLE cycle.
  // mut_at: after that pixel, scramble the channel's inputs and drop req.
  // abort_at: after that pixel, assert reset and stop.
  task automatic run_draw(input int k, input int ch, input string tag, input bit drop,
                          input int mut_at, input int abort_at);
    logic [2:0] oh;
    pix_t       e;
    oh = 3'b001 << ch;
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s/ctl%0d", tag, i),
            32'({grant_v[k], done_v[k], busy_v[k], plot_v[k]}),
            32'({oh, 3'b000, 1'b1, e.p}));
      if (e.p)
        check($sformatf("%s/pix%0d", tag, i),
              32'({x_v[k], y_v[k], colour_v[k]}), 32'({e.x, e.y, e.c}));
      if (i == mut_at) begin
        tx_v[k][ch]  = 7'd30;
        col_v[k][ch] = 3'd7;
        req_v[k][ch] = 1'b0;
      end
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, "/abort"},
              32'({grant_v[k], done_v[k], busy_v[k], plot_v[k]}), 32'd0);
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
    check({tag, "/done"}, 32'({grant_v[k], done_v[k], busy_v[k], plot_v[k]}),
          32'({oh, oh, 1'b1, 1'b0}));
    if (drop) req_v[k][ch] = 1'b0;
    @(negedge clk);
    check({tag, "/idle"}, 32'({grant_v[k], done_v[k], busy_v[k]}), 32'd0);
  endtask

  initial begin
    int at;
    int prev;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      req_v[k] = '0;
      for (int c = 0; c < 3; c++) begin
        tx_v[k][c]  = '0;
        ty_v[k][c]  = '0;
        col_v[k][c] = '0;
      end
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++)
      check($sformatf("reset%0d", k),
            32'({grant_v[k], done_v[k], busy_v[k], plot_v[k], x_v[k], y_v[k], colour_v[k]}),
            32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single request, defaults.
    tx_v[0][0] = 7'd2; ty_v[0][0] = 7'd3; col_v[0][0] = 3'd1;
    req_v[0] = 3'b001;
    push_tile(0, 2, 3, 3'd1);
    wait_grant(0, 3'b001, "t1", at);
    run_draw(0, 0, "t1", 1'b1, -1, -1);

    // 2: fixed priority, three requesters, ch0 re-raises during ch1's draw.
    tx_v[0][0] = 7'd1; ty_v[0][0] = 7'd1; col_v[0][0] = 3'd1;
    tx_v[0][1] = 7'd2; ty_v[0][1] = 7'd2; col_v[0][1] = 3'd2;
    tx_v[0][2] = 7'd3; ty_v[0][2] = 7'd3; col_v[0][2] = 3'd3;
    req_v[0] = 3'b111;
    push_tile(0, 1, 1, 3'd1);
    wait_grant(0, 3'b001, "t2a", at);
    run_draw(0, 0, "t2a", 1'b1, -1, -1);
    push_tile(0, 2, 2, 3'd2);
    wait_grant(0, 3'b010, "t2b", at);
    req_v[0][0] = 1'b1;
    run_draw(0, 1, "t2b", 1'b1, -1, -1);
    push_tile(0, 1, 1, 3'd1);
    wait_grant(0, 3'b001, "t2c", at);
    run_draw(0, 0, "t2c", 1'b1, -1, -1);
    push_tile(0, 3, 3, 3'd3);
    wait_grant(0, 3'b100, "t2d", at);
    run_draw(0, 2, "t2d", 1'b1, -1, -1);

    // 3: round-robin with all requests held; 18-cycle spacing.
    for (int c = 0; c < 3; c++) begin
      tx_v[1][c] = 7'(c); ty_v[1][c] = 7'd0; col_v[1][c] = 3'(c + 1);
    end
    req_v[1] = 3'b111;
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      push_tile(1, j % 3, 0, 3'(j % 3 + 1));
      wait_grant(1, 3'b001 << (j % 3), $sformatf("t3_%0d", j), at);
      if (j > 0) check($sformatf("t3_%0d/spacing", j), 32'(at - prev), 32'd18);
      prev = at;
      if (j == 4) req_v[1] = 3'b000;
      run_draw(1, j % 3, $sformatf("t3_%0d", j), 1'b0, -1, -1);
    end

    // 4: clipping at the right/bottom screen edge.
    tx_v[2][0] = 7'd79; ty_v[2][0] = 7'd59; col_v[2][0] = 3'd5;
    req_v[2] = 3'b001;
    push_tile(2, 79, 59, 3'd5);
    wait_grant(2, 3'b001, "t4a", at);
    run_draw(2, 0, "t4a", 1'b1, -1, -1);
    tx_v[2][1] = 7'd80; ty_v[2][1] = 7'd0; col_v[2][1] = 3'd6;
    req_v[2] = 3'b010;
    push_tile(2, 80, 0, 3'd6);
    wait_grant(2, 3'b010, "t4b", at);
    run_draw(2, 1, "t4b", 1'b1, -1, -1);
    tx_v[3][2] = 7'd79; ty_v[3][2] = 7'd0; col_v[3][2] = 3'd4;
    req_v[3] = 3'b100;
    push_tile(3, 79, 0, 3'd4);
    wait_grant(3, 3'b100, "t4c", at);
    run_draw(3, 2, "t4c", 1'b1, -1, -1);

    // 5: inputs change and req drops mid-draw; latched values are used.
    tx_v[0][2] = 7'd5; ty_v[0][2] = 7'd6; col_v[0][2] = 3'd2;
    req_v[0] = 3'b100;
    push_tile(0, 5, 6, 3'd2);
    wait_grant(0, 3'b100, "t5", at);
    run_draw(0, 2, "t5", 1'b1, 4, -1);

    // 6: reset mid-draw, then round-robin restarts from ch0.
    tx_v[1][1] = 7'd3; ty_v[1][1] = 7'd1; col_v[1][1] = 3'd5;
    req_v[1] = 3'b010;
    push_tile(1, 3, 1, 3'd5);
    wait_grant(1, 3'b010, "t6a", at);
    run_draw(1, 1, "t6a", 1'b1, -1, 6);
    @(negedge clk);
    check("t6/nodone", 32'({grant_v[1], done_v[1], busy_v[1], plot_v[1]}), 32'd0);
    rst = 1'b0;
    tx_v[1][2] = 7'd4; ty_v[1][2] = 7'd2; col_v[1][2] = 3'd6;
    req_v[1] = 3'b110;
    push_tile(1, 3, 1, 3'd5);
    wait_grant(1, 3'b010, "t6b", at);
    run_draw(1, 1, "t6b", 1'b1, -1, -1);
    push_tile(1, 4, 2, 3'd6);
    wait_grant(1, 3'b100, "t6c", at);
    run_draw(1, 2, "t6c", 1'b1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
